// File: rtl/melody_sequencer.sv
// Table-driven note sequencer. Walks an external synchronous note ROM of
// {freq, dur} entries and drives each frequency to the PWM tone generator for
// dur millisecond ticks, followed by a fixed silent gap. Supports start, stop,
// pause, looping and end-of-song detection. All outputs are registered.
module melody_sequencer #(
    parameter int unsigned FREQ_W = 14,
    parameter int unsigned DUR_W  = 12,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned GAP_MS = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick_msec,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [FREQ_W+DUR_W-1:0] rom_data,
    output logic [FREQ_W-1:0]       freq,
    output logic                    playing,
    output logic                    paused,
    output logic                    done
);

    // One counter serves both note duration and gap length.
    localparam int unsigned GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam int unsigned CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [CNT_W-1:0]  GAP_LAST  = (GAP_MS > 0) ? CNT_W'(GAP_MS - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StGap,
        StAdvance,
        StEnd,
        StPause
    } state_e;

    state_e             state;
    state_e             ret_state;
    logic [FREQ_W-1:0]  note_freq;
    logic [DUR_W-1:0]   note_last;
    logic [CNT_W-1:0]   count;
    logic [FREQ_W-1:0]  rom_freq;
    logic [DUR_W-1:0]   rom_dur;

    assign rom_freq = rom_data[FREQ_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    // Sequencer FSM; priority is stop > pause > tick/sequencing > start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            ret_state <= StPlay;
            note_freq <= '0;
            note_last <= '0;
            count     <= '0;
            rom_addr  <= '0;
            freq      <= '0;
            playing   <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && (state != StIdle)) begin
                state    <= StIdle;
                count    <= '0;
                rom_addr <= '0;
                freq     <= '0;
                playing  <= 1'b0;
                paused   <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start && !stop) begin
                            rom_addr <= '0;
                            playing  <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                    StFetch: begin
                        // ROM output becomes valid one cycle after the address.
                        state <= StLoad;
                    end
                    StLoad: begin
                        note_freq <= rom_freq;
                        note_last <= rom_dur - DUR_W'(1);
                        count     <= '0;
                        if (rom_dur == '0) begin
                            state <= StEnd;
                        end else if (pause) begin
                            // A pause seen earlier lands here instead of in PLAY.
                            ret_state <= StPlay;
                            paused    <= 1'b1;
                            state     <= StPause;
                        end else begin
                            freq  <= rom_freq;
                            state <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (pause) begin
                            ret_state <= StPlay;
                            paused    <= 1'b1;
                            freq      <= '0;
                            state     <= StPause;
                        end else if (tick_msec) begin
                            if (count == CNT_W'(note_last)) begin
                                count <= '0;
                                freq  <= '0;
                                state <= (GAP_MS > 0) ? StGap : StAdvance;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    StGap: begin
                        if (pause) begin
                            ret_state <= StGap;
                            paused    <= 1'b1;
                            state     <= StPause;
                        end else if (tick_msec) begin
                            if (count == GAP_LAST) begin
                                count <= '0;
                                state <= StAdvance;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    StAdvance: begin
                        // The last ROM slot acts as an implicit end marker.
                        if (rom_addr == ADDR_LAST) begin
                            state <= StEnd;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= StFetch;
                        end
                    end
                    StEnd: begin
                        // Never loop an empty song: that would spin forever.
                        if (loop_en && (rom_addr != '0)) begin
                            rom_addr <= '0;
                            state    <= StFetch;
                        end else begin
                            done     <= 1'b1;
                            playing  <= 1'b0;
                            rom_addr <= '0;
                            state    <= StIdle;
                        end
                    end
                    StPause: begin
                        if (!pause) begin
                            paused <= 1'b0;
                            state  <= ret_state;
                            if (ret_state == StPlay) begin
                                freq <= note_freq;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
